// File: rtl/mem_arbiter.sv
// Two-to-one line-memory arbiter: I-cache and D-cache miss ports share one slow memory.
// One transaction at a time; the winner's request is latched and the winner gets a one-cycle ready pulse.
module mem_arbiter #(
    parameter int LINE_W     = 128,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [31:4]       i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:4]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:4]       mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t              state_r, state_nxt_s;
    logic                last_grant_r, last_grant_nxt_s;
    logic                mem_read_r, mem_read_nxt_s;
    logic                mem_write_r, mem_write_nxt_s;
    logic [31:4]         mem_addr_r, mem_addr_nxt_s;
    logic [LINE_W-1:0]   mem_wdata_r, mem_wdata_nxt_s;
    logic [LINE_W-1:0]   i_rdata_r, i_rdata_nxt_s;
    logic [LINE_W-1:0]   d_rdata_r, d_rdata_nxt_s;
    logic                i_ready_r, i_ready_nxt_s;
    logic                d_ready_r, d_ready_nxt_s;
    logic                i_req_s, d_req_s, pick_d_s;

    assign i_req_s = i_read | i_write;
    assign d_req_s = d_read | d_write;
    // D wins when alone, under fixed priority, or when I held the previous grant.
    assign pick_d_s = d_req_s & (~i_req_s | (FIXED_PRIO != 0) | (last_grant_r == GRANT_I));

    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign i_rdata   = i_rdata_r;
    assign i_ready   = i_ready_r;
    assign d_rdata   = d_rdata_r;
    assign d_ready   = d_ready_r;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt_s      = state_r;
        last_grant_nxt_s = last_grant_r;
        mem_read_nxt_s   = mem_read_r;
        mem_write_nxt_s  = mem_write_r;
        mem_addr_nxt_s   = mem_addr_r;
        mem_wdata_nxt_s  = mem_wdata_r;
        i_rdata_nxt_s    = i_rdata_r;
        d_rdata_nxt_s    = d_rdata_r;
        i_ready_nxt_s    = 1'b0;
        d_ready_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_d_s) begin
                    state_nxt_s      = ST_BUSY_D;
                    last_grant_nxt_s = GRANT_D;
                    mem_write_nxt_s  = d_write;
                    mem_read_nxt_s   = d_read & ~d_write;
                    mem_addr_nxt_s   = d_addr;
                    mem_wdata_nxt_s  = d_wdata;
                end else if (i_req_s) begin
                    state_nxt_s      = ST_BUSY_I;
                    last_grant_nxt_s = GRANT_I;
                    mem_write_nxt_s  = i_write;
                    mem_read_nxt_s   = i_read & ~i_write;
                    mem_addr_nxt_s   = i_addr;
                    mem_wdata_nxt_s  = i_wdata;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (mem_ready) begin
                    state_nxt_s     = ST_RESP;
                    mem_read_nxt_s  = 1'b0;
                    mem_write_nxt_s = 1'b0;
                    if (state_r == ST_BUSY_D) begin
                        d_ready_nxt_s = 1'b1;
                        d_rdata_nxt_s = mem_read_r ? mem_rdata : d_rdata_r;
                    end else begin
                        i_ready_nxt_s = 1'b1;
                        i_rdata_nxt_s = mem_read_r ? mem_rdata : i_rdata_r;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            // No grant here, so a request not yet dropped after ready is not re-served.
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= GRANT_I;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= 28'd0;
            mem_wdata_r  <= {LINE_W{1'b0}};
            i_rdata_r    <= {LINE_W{1'b0}};
            d_rdata_r    <= {LINE_W{1'b0}};
            i_ready_r    <= 1'b0;
            d_ready_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            mem_read_r   <= mem_read_nxt_s;
            mem_write_r  <= mem_write_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
            i_rdata_r    <= i_rdata_nxt_s;
            d_rdata_r    <= d_rdata_nxt_s;
            i_ready_r    <= i_ready_nxt_s;
            d_ready_r    <= d_ready_nxt_s;
        end
    end

endmodule
